// File: rtl/sram_a_tile_reader_if.sv
// Byte stream from the A-tile reader to the systolic-array A-feeder.
interface sram_a_tile_reader_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last_col;
  logic              last;

  modport master (output valid, output data, output last_col, output last, input ready);
  modport slave  (input valid, input data, input last_col, input last, output ready);
endinterface

// File: rtl/sram_a_tile_reader.sv
// Walks a rectangular tile of the A-operand SRAM row-major and streams the bytes out,
// hiding the 1-cycle SRAM read latency behind a small skid FIFO.
module sram_a_tile_reader #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DIM_W      = 6,
  parameter int unsigned SKID_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [DIM_W-1:0]       rows,
  input  logic [DIM_W-1:0]       cols,
  input  logic [ADDR_W-1:0]      row_stride,
  output logic                   busy,
  output logic                   done,
  output logic                   sram_ce,
  output logic                   sram_we,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [DATA_W-1:0]      sram_din,
  input  logic [DATA_W-1:0]      sram_dout,
  sram_a_tile_reader_if.master   m
);

  localparam int unsigned PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   row_base, stride_q;
  logic [DIM_W-1:0]    col, row, rows_q, cols_q;
  logic                infl_q, infl_last_col_q, infl_last_q;
  logic [DATA_W-1:0]   fifo_data [SKID_DEPTH];
  logic                fifo_lc   [SKID_DEPTH];
  logic                fifo_l    [SKID_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    fifo_count;
  logic                push, pop, load, room, last_col_c, last_row_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign sram_we    = 1'b0;
  assign sram_din   = '0;
  assign sram_addr  = row_base + ADDR_W'(col);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign load       = (state == S_IDLE) && start;
  assign push       = infl_q;
  assign pop        = m.valid && m.ready;
  assign last_col_c = (col == cols_q - DIM_W'(1));
  assign last_row_c = (row == rows_q - DIM_W'(1));
  // Issue only if everything already owed to the FIFO still leaves a free slot after this cycle's pop.
  assign room       = (OCC_W'(fifo_count) + OCC_W'(infl_q)) < (OCC_W'(SKID_DEPTH) + OCC_W'(pop));

  assign m.valid    = (fifo_count != '0);
  assign m.data     = fifo_data[rd_ptr];
  assign m.last_col = m.valid && fifo_lc[rd_ptr];
  assign m.last     = m.valid && fifo_l[rd_ptr];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and read-issue decode.
  always_comb begin
    state_nxt = state;
    sram_ce   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = (rows != '0 && cols != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        sram_ce = room;
        if (room && last_col_c && last_row_c) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && m.last) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Tile parameters and row/column walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_base <= '0;
      stride_q <= '0;
      col      <= '0;
      row      <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
    end else if (load) begin
      row_base <= base_addr;
      stride_q <= row_stride;
      col      <= '0;
      row      <= '0;
      rows_q   <= rows;
      cols_q   <= cols;
    end else if (sram_ce) begin
      if (last_col_c) begin
        col      <= '0;
        row      <= row + DIM_W'(1);
        row_base <= row_base + stride_q;
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

  // Sidebands travel alongside the outstanding SRAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      infl_q          <= 1'b0;
      infl_last_col_q <= 1'b0;
      infl_last_q     <= 1'b0;
    end else begin
      infl_q          <= sram_ce;
      infl_last_col_q <= last_col_c;
      infl_last_q     <= last_col_c && last_row_c;
    end
  end

  // Skid FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (!push && pop) fifo_count <= fifo_count - CNT_W'(1);
    end
  end

  // Skid FIFO storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= sram_dout;
      fifo_lc[wr_ptr]   <= infl_last_col_q;
      fifo_l[wr_ptr]    <= infl_last_q;
    end
  end

  // The issue rule guarantees a free slot for every returning read.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && fifo_count == CNT_W'(SKID_DEPTH)));

endmodule

// File: tb/tb_sram_a_tile_reader.sv
// Directed bench for sram_a_tile_reader with an SRAM model and stream monitor.
module tb_sram_a_tile_reader;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIM_W  = 6;
  localparam int          SKID   = 2;

  logic              clk = 1'b0;
  logic              rst, start, busy, done, sram_ce, sram_we;
  logic [ADDR_W-1:0] base_addr, row_stride, sram_addr;
  logic [DIM_W-1:0]  rows, cols;
  logic [DATA_W-1:0] sram_din, sram_dout;
  logic [DATA_W-1:0] sram_mem [1024];

  sram_a_tile_reader_if #(.DATA_W(DATA_W)) m_if ();

  sram_a_tile_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W), .SKID_DEPTH(SKID)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .rows(rows), .cols(cols),
    .row_stride(row_stride), .busy(busy), .done(done), .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout), .m(m_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM with one-cycle registered read.
  always @(posedge clk) if (sram_ce) sram_dout <= sram_mem[sram_addr];

  // Ready patterns: 0 always, 1 toggles 1,0,0,1, 2 random, 3 never.
  int ready_mode = 3;
  int pidx = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_if.ready = 1'b1;
      1:       m_if.ready = (pidx % 4 == 0) || (pidx % 4 == 3);
      2:       m_if.ready = 1'(($urandom_range(0, 1)));
      default: m_if.ready = 1'b0;
    endcase
    pidx++;
  end

  int checks = 0, errors = 0;
  int ce_addr_q[$], ce_cyc_q[$], beat_cyc_q[$], done_cyc_q[$];
  logic [DATA_W+1:0] beat_q[$];
  int exp_addr_q[$];
  logic [DATA_W+1:0] exp_beat_q[$];
  int out_cnt = 0, max_out = 0, issue_viol = 0, hold_viol = 0, we_viol = 0;
  bit prev_stall = 0;
  logic [DATA_W+1:0] prev_beat;

  // Monitor: logs reads, beats and done; tracks outstanding reads and stall stability.
  always @(negedge clk) begin
    bit pop;
    if (rst) begin
      out_cnt    = 0;
      prev_stall = 0;
    end else begin
      pop = m_if.valid && m_if.ready;
      if (sram_we !== 1'b0 || sram_din !== '0) we_viol++;
      if (sram_ce) begin
        ce_addr_q.push_back(int'(sram_addr));
        ce_cyc_q.push_back(cyc);
        if (out_cnt + 1 - int'(pop) > SKID) issue_viol++;
      end
      if (prev_stall && (!m_if.valid || {m_if.last_col, m_if.last, m_if.data} !== prev_beat)) hold_viol++;
      prev_stall = m_if.valid && !m_if.ready;
      prev_beat  = {m_if.last_col, m_if.last, m_if.data};
      if (pop) begin
        beat_q.push_back({m_if.last_col, m_if.last, m_if.data});
        beat_cyc_q.push_back(cyc);
      end
      out_cnt = out_cnt + int'(sram_ce) - int'(pop);
      if (out_cnt > max_out) max_out = out_cnt;
      if (done) done_cyc_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ce_addr_q.delete(); ce_cyc_q.delete(); beat_q.delete(); beat_cyc_q.delete(); done_cyc_q.delete();
    max_out = 0; issue_viol = 0; hold_viol = 0; we_viol = 0;
  endtask

  // Reference walk of the tile against the SRAM contents.
  task automatic build_exp(input int base, input int nr, input int nc, input int stride);
    int a;
    exp_addr_q.delete();
    exp_beat_q.delete();
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++) begin
        a = (base + r * stride + c) % 1024;
        exp_addr_q.push_back(a);
        exp_beat_q.push_back({c == nc - 1, (r == nr - 1) && (c == nc - 1), sram_mem[a]});
      end
  endtask

  // Pulses start with the given tile and waits (bounded) for done.
  task automatic run_tile(input int base, input int nr, input int nc, input int stride,
                          output int t0, output int tdone, output bit to);
    start = 1'b1; base_addr = ADDR_W'(base); rows = DIM_W'(nr); cols = DIM_W'(nc); row_stride = ADDR_W'(stride);
    t0 = cyc;
    tick();
    start = 1'b0;
    to = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      if (done) begin to = 1'b0; break; end
      tick();
    end
    tdone = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; rows = '0; cols = '0; row_stride = '0;
    ready_mode = 0;
    repeat (3) tick();
    checks++;
    if ({busy, done, sram_ce, sram_addr, m_if.valid, m_if.last, m_if.last_col} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b ce=%b addr=%h valid=%b last=%b last_col=%b required all 0",
               busy, done, sram_ce, sram_addr, m_if.valid, m_if.last, m_if.last_col);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_tile();
    int t0, td; bit to; logic [DATA_W+1:0] got;
    build_exp(16, 2, 3, 32);
    clear_logs(); ready_mode = 0; tick();
    run_tile(16, 2, 3, 32, t0, td, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %0b required 0", to); end
    checks++; if (ce_addr_q.size() != 6) begin errors++; $display("FAIL basic_read_count: got %0d required 6", ce_addr_q.size()); end
    for (int i = 0; i < exp_addr_q.size(); i++) begin
      checks++;
      if (i >= ce_addr_q.size() || ce_addr_q[i] != exp_addr_q[i]) begin
        errors++; $display("FAIL basic_addr[%0d]: got %0h required %0h", i, (i < ce_addr_q.size()) ? ce_addr_q[i] : -1, exp_addr_q[i]);
      end
    end
    checks++; if (ce_cyc_q.size() == 0 || ce_cyc_q[0] != t0 + 1) begin errors++; $display("FAIL basic_first_ce: got %0d required %0d", (ce_cyc_q.size() > 0) ? ce_cyc_q[0] - t0 : -1, 1); end
    checks++; if (beat_q.size() != 6) begin errors++; $display("FAIL basic_beat_count: got %0d required 6", beat_q.size()); end
    for (int i = 0; i < exp_beat_q.size(); i++) begin
      got = (i < beat_q.size()) ? beat_q[i] : 'x;
      checks++;
      if (got !== exp_beat_q[i] || i >= beat_cyc_q.size() || beat_cyc_q[i] != t0 + 3 + i) begin
        errors++; $display("FAIL basic_beat[%0d]: got %h at T+%0d required %h at T+%0d", i, got,
                           (i < beat_cyc_q.size()) ? beat_cyc_q[i] - t0 : -1, exp_beat_q[i], 3 + i);
      end
    end
    checks++; if (td != t0 + 9) begin errors++; $display("FAIL basic_done_time: got T+%0d required T+9", td - t0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_at_done: got %b required 1", busy); end
    tick();
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL basic_idle_after_done: got busy=%b done=%b required 0 0", busy, done); end
    tick();
    checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL basic_done_count: got %0d required 1", done_cyc_q.size()); end
    checks++; if (issue_viol + we_viol != 0) begin errors++; $display("FAIL basic_issue_rule: got %0d violations required 0", issue_viol + we_viol); end
  endtask

  task automatic test_backpressure();
    int t0, td; bit to; logic [DATA_W+1:0] got;
    build_exp(16, 2, 3, 32);
    clear_logs(); ready_mode = 1; tick();
    run_tile(16, 2, 3, 32, t0, td, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %0b required 0", to); end
    checks++; if (beat_q.size() != 6) begin errors++; $display("FAIL bp_beat_count: got %0d required 6", beat_q.size()); end
    for (int i = 0; i < exp_beat_q.size(); i++) begin
      got = (i < beat_q.size()) ? beat_q[i] : 'x;
      checks++; if (got !== exp_beat_q[i]) begin errors++; $display("FAIL bp_beat[%0d]: got %h required %h", i, got, exp_beat_q[i]); end
    end
    checks++; if (max_out > SKID) begin errors++; $display("FAIL bp_occupancy: got %0d required <= %0d", max_out, SKID); end
    checks++; if (issue_viol != 0) begin errors++; $display("FAIL bp_issue_rule: got %0d violations required 0", issue_viol); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold_stable: got %0d violations required 0", hold_viol); end
    checks++; if (ce_cyc_q.size() != 6 || ce_cyc_q[5] - ce_cyc_q[0] <= 5) begin
      errors++; $display("FAIL bp_issue_stall: got %0d reads spanning %0d cycles required 6 reads spanning > 5", ce_cyc_q.size(),
                         (ce_cyc_q.size() == 6) ? ce_cyc_q[5] - ce_cyc_q[0] : -1);
    end
    tick();
    checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL bp_done_count: got %0d required 1", done_cyc_q.size()); end
  endtask

  task automatic test_addr_wrap();
    int t0, td; bit to; logic [DATA_W+1:0] got;
    int exp_a[4] = '{'h3FE, 'h3FF, 'h000, 'h001};
    build_exp('h3FE, 1, 4, 0);
    clear_logs(); ready_mode = 0; tick();
    run_tile('h3FE, 1, 4, 0, t0, td, to);
    checks++; if (to !== 1'b0 || td != t0 + 7) begin errors++; $display("FAIL wrap_done_time: got T+%0d timeout=%0b required T+7", td - t0, to); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= ce_addr_q.size() || ce_addr_q[i] != exp_a[i]) begin
        errors++; $display("FAIL wrap_addr[%0d]: got %0h required %0h", i, (i < ce_addr_q.size()) ? ce_addr_q[i] : -1, exp_a[i]);
      end
      got = (i < beat_q.size()) ? beat_q[i] : 'x;
      checks++; if (got !== exp_beat_q[i]) begin errors++; $display("FAIL wrap_beat[%0d]: got %h required %h", i, got, exp_beat_q[i]); end
    end
    tick();
  endtask

  task automatic test_empty_tile();
    int t0;
    clear_logs(); ready_mode = 0; tick();
    start = 1'b1; base_addr = ADDR_W'('h55); rows = '0; cols = DIM_W'(5); row_stride = ADDR_W'(1);
    t0 = cyc;
    tick();
    checks++; if ({busy, done} !== 2'b11) begin errors++; $display("FAIL empty_busy_done: got busy=%b done=%b required 1 1", busy, done); end
    start = 1'b1; rows = DIM_W'(1); cols = DIM_W'(1);
    tick();
    start = 1'b0;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL empty_ignore_start: got busy=%b done=%b required 0 0", busy, done); end
    repeat (5) tick();
    checks++; if (ce_addr_q.size() + beat_q.size() != 0) begin errors++; $display("FAIL empty_no_traffic: got %0d reads %0d beats required 0 0", ce_addr_q.size(), beat_q.size()); end
    checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != t0 + 1) begin
      errors++; $display("FAIL empty_done: got %0d pulses first at T+%0d required 1 at T+1", done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] - t0 : -1);
    end
  endtask

  task automatic test_reset_abort();
    int t0, td; bit to; logic [DATA_W+1:0] got;
    clear_logs(); ready_mode = 3; tick();
    start = 1'b1; base_addr = ADDR_W'(16); rows = DIM_W'(2); cols = DIM_W'(3); row_stride = ADDR_W'(32);
    tick();
    start = 1'b0;
    repeat (3) tick();
    checks++; if (m_if.valid !== 1'b1 || out_cnt != 2) begin errors++; $display("FAIL abort_fifo_full: got valid=%b held=%0d required 1 2", m_if.valid, out_cnt); end
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, done, sram_ce, sram_addr, m_if.valid, m_if.last, m_if.last_col} !== '0) begin
      errors++; $display("FAIL abort_outputs: got busy=%b done=%b ce=%b addr=%h valid=%b last=%b last_col=%b required all 0",
                         busy, done, sram_ce, sram_addr, m_if.valid, m_if.last, m_if.last_col);
    end
    rst = 1'b0; ready_mode = 0;
    repeat (6) tick();
    checks++; if (done_cyc_q.size() != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses required 0", done_cyc_q.size()); end
    build_exp('h100, 3, 2, 'h40);
    clear_logs();
    run_tile('h100, 3, 2, 'h40, t0, td, to);
    checks++; if (to !== 1'b0 || td != t0 + 9) begin errors++; $display("FAIL abort_restart_done: got T+%0d timeout=%0b required T+9", td - t0, to); end
    for (int i = 0; i < exp_beat_q.size(); i++) begin
      got = (i < beat_q.size()) ? beat_q[i] : 'x;
      checks++; if (got !== exp_beat_q[i]) begin errors++; $display("FAIL abort_restart_beat[%0d]: got %h required %h", i, got, exp_beat_q[i]); end
    end
    tick();
  endtask

  task automatic test_random_tiles();
    int t0, td, nr, nc, base, stride; bit to; logic [DATA_W+1:0] got;
    for (int t = 0; t < 6; t++) begin
      nr = int'($urandom_range(1, 8)); nc = int'($urandom_range(1, 8));
      base = int'($urandom_range(0, 1023)); stride = int'($urandom_range(0, 1023));
      build_exp(base, nr, nc, stride);
      clear_logs(); ready_mode = 2;
      run_tile(base, nr, nc, stride, t0, td, to);
      tick();
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout: got %0b required 0", t, to); end
      checks++; if (beat_q.size() != exp_beat_q.size()) begin errors++; $display("FAIL rand%0d_beat_count: got %0d required %0d", t, beat_q.size(), exp_beat_q.size()); end
      for (int i = 0; i < exp_beat_q.size(); i++) begin
        got = (i < beat_q.size()) ? beat_q[i] : 'x;
        checks++; if (got !== exp_beat_q[i]) begin errors++; $display("FAIL rand%0d_beat[%0d]: got %h required %h", t, i, got, exp_beat_q[i]); end
      end
      checks++; if (done_cyc_q.size() != 1 || issue_viol + hold_viol + we_viol != 0) begin
        errors++; $display("FAIL rand%0d_protocol: got %0d done, %0d violations required 1 0", t, done_cyc_q.size(), issue_viol + hold_viol + we_viol);
      end
    end
    ready_mode = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) sram_mem[i] = DATA_W'(i * 37 + (i >> 5) + 1);
    test_reset();
    test_basic_tile();
    test_backpressure();
    test_addr_wrap();
    test_empty_tile();
    test_reset_abort();
    test_random_tiles();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
